// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM state encoding, flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_PASS = 4'h7,
    OP_ADC  = 4'h8,
    OP_SBB  = 4'h9,
    OP_SAR  = 4'hA,
    OP_MUL  = 4'hB,
    OP_CLRC = 4'hC
  } alu_op_e;

  typedef logic [0:0] alu_state_e;
  localparam alu_state_e ST_IDLE = 1'b0;
  localparam alu_state_e ST_MUL  = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier; one partial product per clock, WIDTH clocks per start.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // product is the accumulator after the current iteration, so it is complete while done is high
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU execution unit with valid/ready handshakes, persistent carry and iterative multiply.
//   state   | meaning
//   ST_IDLE | single-cycle ops accepted whenever the output slot is free
//   ST_MUL  | multiplier iterating; input blocked until the product is loaded
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  alu_op_e            op_e;
  alu_state_e         state_q;
  logic               c_q;
  logic [WIDTH-1:0]   result_q;
  alu_flags_t         flags_q;
  logic               accept;
  logic               out_fire;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               cin;
  logic               bin;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHW-1:0]     shamt;
  logic               shift_big;
  logic [WIDTH-1:0]   res_d;
  logic               c_d;
  logic               c_we;
  logic               ovf_d;
  logic               illegal;
  alu_flags_t         flags_d;
  alu_flags_t         mul_flags;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign mul_start = accept && (op_e == OP_MUL);
  assign busy      = (state_q == ST_MUL);

  assign cin       = (op_e == OP_ADC) && c_q;
  assign bin       = (op_e == OP_SBB) && c_q;
  assign sum_ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff_ext  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  assign shamt     = b[SHW-1:0];
  assign shift_big = (b >= WIDTH'(WIDTH));

  always_comb begin
    res_d   = '0;
    c_d     = c_q;
    c_we    = 1'b0;
    ovf_d   = 1'b0;
    illegal = 1'b0;
    case (op_e)
      OP_ADD, OP_ADC: begin
        res_d = sum_ext[WIDTH-1:0];
        c_d   = sum_ext[WIDTH];
        c_we  = 1'b1;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        res_d = diff_ext[WIDTH-1:0];
        c_d   = diff_ext[WIDTH];
        c_we  = 1'b1;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_SHL:  res_d = shift_big ? '0 : (a << shamt);
      OP_SHR:  res_d = shift_big ? '0 : (a >> shamt);
      OP_SAR:  res_d = shift_big ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> shamt);
      OP_PASS: res_d = a;
      OP_CLRC: begin
        res_d = a;
        c_d   = 1'b0;
        c_we  = 1'b1;
      end
      OP_MUL:  res_d = '0;
      default: illegal = 1'b1;
    endcase
    flags_d.carry    = illegal ? 1'b0 : c_d;
    flags_d.zero     = (res_d == '0);
    flags_d.negative = res_d[WIDTH-1];
    flags_d.overflow = ovf_d;
  end

  assign mul_flags.carry    = c_q;
  assign mul_flags.zero     = (mul_product[WIDTH-1:0] == '0);
  assign mul_flags.negative = mul_product[WIDTH-1];
  assign mul_flags.overflow = |mul_product[2*WIDTH-1:WIDTH];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // A MUL accept always coincides with an empty or draining output slot, so out_valid drops to 0 there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      c_q       <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (op_e == OP_MUL) begin
        state_q   <= ST_MUL;
        out_valid <= 1'b0;
      end else begin
        result_q  <= res_d;
        flags_q   <= flags_d;
        out_valid <= 1'b1;
        if (c_we) c_q <= c_d;
      end
    end else if ((state_q == ST_MUL) && mul_done) begin
      state_q   <= ST_IDLE;
      result_q  <= mul_product[WIDTH-1:0];
      flags_q   <= mul_flags;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's 4-bit combinational ALU. Adds a WIDTH-generic datapath, a valid/ready handshake on input and output, a persistent carry flag for multi-word arithmetic (ADC/SBB), signed flags, barrel shifts, and an iterative multiplier run by a small FSM. Sits between the operand-fetch stage and writeback as a single execution unit.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- a, b  in  WIDTH  operands
- op  in  4  operation code (alu_op_e)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- result  out  WIDTH  registered result
- carry_out, zero, negative, overflow  out  1 each  registered flags
- busy  out  1  multiplier FSM not IDLE

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASS a, 8 ADC (a+b+C), 9 SBB (a-b-C), A SAR, B MUL (low WIDTH bits, unsigned), C CLRC (result=a, C cleared), D-F illegal.
- Internal carry register C: written at accept by ADD/SUB/ADC/SBB (bit WIDTH of the WIDTH+1-bit sum/difference; for SUB/SBB this is borrow) and CLRC (0); all other ops preserve it. carry_out = C after the op.
- overflow: signed overflow for ADD/SUB/ADC/SBB; for MUL, 1 when upper WIDTH product bits are nonzero; 0 otherwise.
- negative = result[WIDTH-1]; zero = (result == 0).
- Shifts use b[SHW-1:0] when b < WIDTH. b >= WIDTH: SHL/SHR give 0, SAR gives all copies of a[WIDTH-1].
- Illegal op: result 0, zero 1, other flags 0, C preserved.
- FSM: IDLE -> MUL on accepted MUL; MUL runs WIDTH shift-add iterations (sub-module); MUL -> IDLE on final iteration, loading output register.

## Timing
- Reset (async assert, sync release): out_valid 0, result 0, all flags 0, C 0, FSM IDLE, busy 0; in_ready 1 from first cycle after release.
- in_ready = (FSM == IDLE) && (!out_valid || out_ready); combinational, no path from in_valid.
- Single-cycle ops: accepted at edge N -> out_valid, result, flags at edge N. Throughput 1/cycle with out_ready high.
- MUL: accepted at edge N -> busy from N; result at edge N+WIDTH; in_ready low for the whole interval.
- Output stall: while out_valid && !out_ready, result/flags/out_valid hold; no new op accepted.
- Same-cycle out transfer and new accept: allowed; output register overwritten, out_valid stays 1.
- ADC/SBB immediately following an arithmetic op sees that op's C (C updates at accept, not at output transfer).
- rst_n low mid-MUL: aborts, all state to reset values; no partial result ever emitted.

## Structure
- alu_pkg: alu_op_e (4-bit enum above), alu_state_e (IDLE, MUL), alu_flags_t struct {carry, zero, negative, overflow}.
- One sub-module: alu_mul_iter (start, a, b -> done, product[2*WIDTH-1:0]; WIDTH-cycle shift-add, same clk/rst_n).
- Top holds combinational single-cycle datapath, C register, output register, FSM.

## Test plan (WIDTH=8)
- ADD 0xFF+0x01 -> result 0x00, carry 1, zero 1, overflow 0, out_valid at accept edge.
- ADD 0x7F+0x01 -> 0x80, negative 1, overflow 1, carry 0; SUB 0x03-0x05 -> 0xFE, carry (borrow) 1, negative 1.
- ADD 0xFF+0x01 then ADC 0x00+0x00 -> 0x01, carry 0; CLRC then ADC 0x00+0x00 -> 0x00, zero 1.
- SHL 0x81 by 1 -> 0x02; SAR 0x80 by 9 -> 0xFF; SHR 0x80 by 8 -> 0x00; op 0xE -> 0x00, zero 1.
- MUL 0x10*0x10 -> result 0x00, overflow 1, zero 1, out_valid exactly 8 cycles after accept, in_ready low meanwhile; repeat with rst_n pulsed at cycle 4 -> out_valid never rises, in_ready 1 after release.
- Back-to-back ADDs with out_ready low 3 cycles -> result held stable, in_ready 0; one op per cycle once out_ready high, no ops lost or duplicated.
